bip_prog_loader: RTL and testbench
==================================

Name: bip_prog_loader

Overview:
UART program loader that sits directly upstream of the BIP processor's program ROM. It receives a framed program image as bytes from the UART receiver and assembles 16-bit instruction words. It writes those words into program memory while holding the processor in reset, then answers with an ACK/NAK byte through the UART transmitter. Once a load is accepted it releases the processor.

Parameters:
WORD_WIDTH, 16, instruction word width; fixed at 2 bytes, high byte first.
MEM_SIZE_ROM, 9, program-memory address width.
TIMEOUT_CYCLES, 1000000, maximum idle clocks allowed between bytes inside a frame.
HDR_BYTE, 8'hA5, frame start byte.

Ports:
i_clock  in  1  system clock.
i_reset  in  1  asynchronous, active-low reset.
i_rx_data  in  8  byte from UART RX; valid only when i_rx_done=1.
i_rx_done  in  1  one-cycle strobe marking a received byte.
i_tx_done  in  1  one-cycle strobe when the UART TX finishes a byte.
o_tx_start  out  1  one-cycle strobe requesting transmission of o_tx_data.
o_tx_data  out  8  response byte: 8'h06 ACK or 8'h15 NAK.
o_we  out  1  program-memory write enable, one-cycle pulse.
o_waddr  out  MEM_SIZE_ROM  write address.
o_wdata  out  WORD_WIDTH  write data.
o_cpu_hold  out  1  holds the processor in reset while 1.
o_done  out  1  last load accepted.
o_error  out  1  last load rejected (sticky).

Behaviour:
Reset (i_reset=0, asynchronous):
- state IDLE.
- o_cpu_hold=1; every other output 0.
- word counter, address, checksum and timeout counter all 0.

Frame format: HDR_BYTE, N (word count, 1..255), then N words sent hi byte then lo byte, then CHK. CHK is the XOR of all 2N data bytes; it covers neither HDR_BYTE nor N.

States:
- IDLE: on i_rx_done with i_rx_data==HDR_BYTE go to COUNT, set o_cpu_hold=1, clear o_done/o_error. Any other byte is ignored.
- COUNT: latch N; clear address and checksum.
  - N==0: go to RESP with NAK, set o_error.
  - N>0: go to HI.
- HI: latch the high byte; checksum ^= byte; go to LO.
- LO: on the byte strobe, the next cycle drives o_we=1, o_waddr=addr, o_wdata={hi,lo}; checksum ^= byte; addr+1.
  - After the Nth word go to CHK, otherwise go to HI.
- CHK:
  - byte==checksum: RESP with ACK, set o_done.
  - byte!=checksum: RESP with NAK, set o_error.
- RESP: o_tx_start=1 for exactly one cycle with o_tx_data stable; go to WAIT_TX.
- WAIT_TX: hold o_tx_data until i_tx_done.
  - ACK sent: go to RUN.
  - NAK sent: go to IDLE.
- RUN: o_cpu_hold=0. A HDR_BYTE reasserts o_cpu_hold on the next cycle and goes to COUNT (reload). Other bytes are ignored.

Timeout:
- Active in COUNT, HI, LO and CHK.
- The counter clears on every i_rx_done.
- When it reaches TIMEOUT_CYCLES-1: go to RESP with NAK, set o_error.
- Words already written stay in memory, but the processor is not released.

Boundaries and simultaneous events:
- i_rx_done during RESP/WAIT_TX is dropped.
- o_waddr does not wrap: N ≤ 255 < 2^MEM_SIZE_ROM.
- o_done and o_error are never 1 together.
- o_error stays set until the next HDR_BYTE.
- Reset mid-frame returns to IDLE with the hold asserted; no o_we pulse may follow reset.

Latency:
- o_we comes 1 cycle after the lo-byte strobe.
- o_tx_start comes 1 cycle after entering RESP.
- The CHK byte strobe to o_tx_start is 2 cycles.

Decomposition:
- Shared package bip_loader_pkg holds:
  - the state enum (IDLE, COUNT, HI, LO, CHK, RESP, WAIT_TX, RUN);
  - localparams ACK=8'h06, NAK=8'h15;
  - the HDR_BYTE default.
- One natural sub-module, bip_loader_timeout: a counter with clear, enable and expire strobe, parameterised by TIMEOUT_CYCLES.
- The FSM, checksum and address logic stay in bip_prog_loader.
- Instantiated inside full_top between the UART RX and the program ROM write port.

Test Plan:
1. Valid load: send A5 02 12 34 AB CD 40 → o_we at addr 0 with 16'h1234, then addr 1 with 16'hABCD. o_tx_start with 8'h06, o_done=1; after i_tx_done, o_cpu_hold=0.
2. Bad checksum: same frame with CHK=41 → two writes occur, NAK 8'h15 sent, o_error=1, o_cpu_hold stays 1, state IDLE.
3. Zero count: A5 00 → NAK immediately, no o_we, o_error=1.
4. Timeout: A5 01 12, then silence for TIMEOUT_CYCLES (set to 50 in the bench) → NAK, o_error=1, hold=1. A following valid frame A5 01 55 AA FF is accepted.
5. Noise and reload: bytes 00 FF 5A before A5 01 00 07 07 are ignored, load is ACKed. A later A5 while in RUN reasserts o_cpu_hold on the next cycle.
6. Reset mid-frame: pull i_reset low after the hi byte of word 0 → all outputs at reset values, no o_we. A fresh frame loads correctly from addr 0.

Source files
------------

// File: rtl/bip_loader_pkg.sv
// Shared definitions for the BIP UART program loader: FSM encoding, response bytes and
// the default frame header.
package bip_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t COUNT   = 3'd1;
  localparam state_t HI      = 3'd2;
  localparam state_t LO      = 3'd3;
  localparam state_t CHK     = 3'd4;
  localparam state_t RESP    = 3'd5;
  localparam state_t WAIT_TX = 3'd6;
  localparam state_t RUN     = 3'd7;

  localparam logic [7:0] ACK              = 8'h06;
  localparam logic [7:0] NAK              = 8'h15;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(state_t s);
    return (s == COUNT) || (s == HI) || (s == LO) || (s == CHK);
  endfunction

endpackage

// File: rtl/bip_prog_loader_if.sv
// Byte-stream, response and program-memory write signals between the loader and its
// surroundings (UART RX/TX, program ROM, CPU reset).
interface bip_prog_loader_if #(
  parameter int unsigned MEM_SIZE_ROM = 9,
  parameter int unsigned WORD_WIDTH   = 16
);
  logic [7:0]              i_rx_data;
  logic                    i_rx_done;
  logic                    i_tx_done;
  logic                    o_tx_start;
  logic [7:0]              o_tx_data;
  logic                    o_we;
  logic [MEM_SIZE_ROM-1:0] o_waddr;
  logic [WORD_WIDTH-1:0]   o_wdata;
  logic                    o_cpu_hold;
  logic                    o_done;
  logic                    o_error;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done,
    output o_tx_start, o_tx_data, o_we, o_waddr, o_wdata, o_cpu_hold, o_done, o_error
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done,
    input  o_tx_start, o_tx_data, o_we, o_waddr, o_wdata, o_cpu_hold, o_done, o_error
  );
endinterface

// File: rtl/bip_loader_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and strobes
// o_expire on the cycle the count reaches TIMEOUT_CYCLES-1.
module bip_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (i_clear || !i_enable) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_expire = i_enable && !i_clear && (cnt_q == LAST);

endmodule

// File: rtl/bip_prog_loader.sv
// UART program loader: parses HDR/N/words/CHK frames, writes words into program ROM
// while holding the CPU in reset, then answers ACK/NAK and releases the CPU on ACK.
module bip_prog_loader
  import bip_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned MEM_SIZE_ROM   = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT
) (
  input logic               i_clock,
  input logic               i_reset,
  bip_prog_loader_if.master bus
);
  localparam int unsigned AW = MEM_SIZE_ROM;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [7:0]            chk_q, chk_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            resp_q, resp_d;
  logic                  tx_start_q, tx_start_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  expire;

  bip_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (bus.i_rx_done),
    .i_enable(in_frame(state_q)),
    .o_expire(expire)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    addr_d     = addr_q;
    chk_d      = chk_q;
    hi_d       = hi_q;
    resp_d     = resp_q;
    tx_start_d = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      IDLE, RUN: begin
        if (bus.i_rx_done && bus.i_rx_data == HDR_BYTE) begin
          state_d = COUNT;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      COUNT, HI, LO, CHK: begin
        if (bus.i_rx_done) begin
          unique case (state_q)
            COUNT: begin
              n_d    = bus.i_rx_data;
              addr_d = '0;
              chk_d  = '0;
              if (bus.i_rx_data == 8'd0) begin
                state_d = RESP;
                resp_d  = NAK;
                error_d = 1'b1;
              end else begin
                state_d = HI;
              end
            end
            HI: begin
              hi_d    = bus.i_rx_data;
              chk_d   = chk_q ^ bus.i_rx_data;
              state_d = LO;
            end
            LO: begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = WORD_WIDTH'({hi_q, bus.i_rx_data});
              chk_d   = chk_q ^ bus.i_rx_data;
              addr_d  = addr_q + 1'b1;
              state_d = (addr_q + 1'b1 == AW'(n_q)) ? CHK : HI;
            end
            default: begin
              state_d = RESP;
              if (bus.i_rx_data == chk_q) begin
                resp_d = ACK;
                done_d = 1'b1;
              end else begin
                resp_d  = NAK;
                error_d = 1'b1;
              end
            end
          endcase
        end else if (expire) begin
          // Partial frame: written words stay in ROM, CPU stays held.
          state_d = RESP;
          resp_d  = NAK;
          error_d = 1'b1;
        end
      end
      RESP: begin
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (resp_q == ACK) begin
            state_d = RUN;
            hold_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      addr_q     <= '0;
      chk_q      <= '0;
      hi_q       <= '0;
      resp_q     <= '0;
      tx_start_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      chk_q      <= chk_d;
      hi_q       <= hi_d;
      resp_q     <= resp_d;
      tx_start_q <= tx_start_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = resp_q;
  assign bus.o_we       = we_q;
  assign bus.o_waddr    = waddr_q;
  assign bus.o_wdata    = wdata_q;
  assign bus.o_cpu_hold = hold_q;
  assign bus.o_done     = done_q;
  assign bus.o_error    = error_q;

endmodule

// File: tb/tb_bip_prog_loader.sv
// Randomized bench for bip_prog_loader: a frame-level reference model predicts every
// output each cycle; directed frames pin the model with literal expectations.
module tb_bip_prog_loader;
  localparam int unsigned T = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bip_prog_loader_if #(.MEM_SIZE_ROM(9), .WORD_WIDTH(16)) bus ();

  bip_prog_loader #(
    .WORD_WIDTH(16), .MEM_SIZE_ROM(9), .TIMEOUT_CYCLES(T), .HDR_BYTE(8'hA5)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int vecs = 0;
  int misc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame, running XOR, pending response.
  localparam int M_WAIT = 0, M_FRAME = 1, M_RESP = 2, M_TX = 3;
  int         mode, pos, quiet;
  logic [7:0] n_m, xr, hi_m;
  logic       exp_we, exp_tx_start, exp_hold, exp_done, exp_err;
  logic [8:0] exp_waddr;
  logic [15:0] exp_wdata;
  logic [7:0] exp_txd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = M_WAIT; pos = 0; quiet = 0; n_m = 0; xr = 0; hi_m = 0;
      exp_we = 0; exp_tx_start = 0; exp_hold = 1; exp_done = 0; exp_err = 0;
      exp_waddr = 0; exp_wdata = 0; exp_txd = 0;
    end else begin
      exp_we = 0;
      exp_tx_start = 0;
      case (mode)
        M_WAIT: if (bus.i_rx_done && bus.i_rx_data == 8'hA5) begin
          mode = M_FRAME; pos = 0; quiet = 0;
          exp_hold = 1; exp_done = 0; exp_err = 0;
        end
        M_FRAME: if (bus.i_rx_done) begin
          quiet = 0;
          if (pos == 0) begin
            n_m = bus.i_rx_data; xr = 0;
            if (n_m == 0) begin mode = M_RESP; exp_txd = 8'h15; exp_err = 1; end
          end else if (pos <= 2 * int'(n_m)) begin
            xr ^= bus.i_rx_data;
            if (pos % 2 == 1) hi_m = bus.i_rx_data;
            else begin
              exp_we = 1; exp_waddr = 9'(pos / 2 - 1); exp_wdata = {hi_m, bus.i_rx_data};
            end
          end else begin
            mode = M_RESP;
            if (bus.i_rx_data == xr) begin exp_txd = 8'h06; exp_done = 1; end
            else begin exp_txd = 8'h15; exp_err = 1; end
          end
          pos++;
        end else if (quiet == int'(T) - 1) begin
          mode = M_RESP; exp_txd = 8'h15; exp_err = 1;
        end else begin
          quiet++;
        end
        M_RESP: begin exp_tx_start = 1; mode = M_TX; end
        default: if (bus.i_tx_done) begin
          mode = M_WAIT;
          if (exp_txd == 8'h06) exp_hold = 0;
        end
      endcase
    end
  end

  logic [8:0]  wa_q[$];
  logic [15:0] wd_q[$];
  logic [7:0]  tx_q[$];

  always @(negedge clk) if (cmp_en) begin
    chk("we", 32'(bus.o_we), 32'(exp_we));
    chk("tx_start", 32'(bus.o_tx_start), 32'(exp_tx_start));
    chk("tx_data", 32'(bus.o_tx_data), 32'(exp_txd));
    chk("cpu_hold", 32'(bus.o_cpu_hold), 32'(exp_hold));
    chk("done", 32'(bus.o_done), 32'(exp_done));
    chk("error", 32'(bus.o_error), 32'(exp_err));
    if (exp_we) begin
      chk("waddr", 32'(bus.o_waddr), 32'(exp_waddr));
      chk("wdata", 32'(bus.o_wdata), 32'(exp_wdata));
    end
    if (bus.o_we) begin wa_q.push_back(bus.o_waddr); wd_q.push_back(bus.o_wdata); end
    if (bus.o_tx_start) tx_q.push_back(bus.o_tx_data);
  end

  // UART TX stand-in: finishes each requested byte after a random delay.
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [7:0] fr[$];

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk);
    #1 bus.i_rx_done = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_frame(input int maxgap);
    foreach (fr[i]) send_byte(fr[i], $urandom_range(0, maxgap));
  endtask

  int w0, t0, n;
  logic [7:0] x, b;

  initial begin
    rst_n = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
    cmp_en = 1'b1;
    idle(3);
    chk("reset_hold", 32'(bus.o_cpu_hold), 32'd1);
    chk("reset_txdata", 32'(bus.o_tx_data), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Valid two-word load
    w0 = wa_q.size(); t0 = tx_q.size();
    fr = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(2);
    idle(12);
    chk("t1_nwrites", 32'(wa_q.size() - w0), 32'd2);
    chk("t1_addr0", 32'(wa_q[w0]), 32'd0);
    chk("t1_data0", 32'(wd_q[w0]), 32'h1234);
    chk("t1_addr1", 32'(wa_q[w0+1]), 32'd1);
    chk("t1_data1", 32'(wd_q[w0+1]), 32'hABCD);
    chk("t1_resp", 32'(tx_q[t0]), 32'h06);
    chk("t1_hold", 32'(bus.o_cpu_hold), 32'd0);
    chk("t1_done", 32'(bus.o_done), 32'd1);

    // Bad checksum
    w0 = wa_q.size(); t0 = tx_q.size();
    fr = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(1);
    idle(12);
    chk("t2_nwrites", 32'(wa_q.size() - w0), 32'd2);
    chk("t2_resp", 32'(tx_q[t0]), 32'h15);
    chk("t2_error", 32'(bus.o_error), 32'd1);
    chk("t2_hold", 32'(bus.o_cpu_hold), 32'd1);

    // Zero count
    w0 = wa_q.size(); t0 = tx_q.size();
    fr = {8'hA5, 8'h00};
    send_frame(0);
    idle(12);
    chk("t3_nwrites", 32'(wa_q.size() - w0), 32'd0);
    chk("t3_resp", 32'(tx_q[t0]), 32'h15);
    chk("t3_error", 32'(bus.o_error), 32'd1);

    // Timeout, then a valid frame
    t0 = tx_q.size();
    fr = {8'hA5, 8'h01, 8'h12};
    send_frame(1);
    idle(T + 15);
    chk("t4_resp", 32'(tx_q[t0]), 32'h15);
    chk("t4_error", 32'(bus.o_error), 32'd1);
    chk("t4_hold", 32'(bus.o_cpu_hold), 32'd1);
    fr = {8'hA5, 8'h01, 8'h55, 8'hAA, 8'hFF};
    send_frame(1);
    idle(12);
    chk("t4_resp2", 32'(tx_q[t0+1]), 32'h06);
    chk("t4_hold2", 32'(bus.o_cpu_hold), 32'd0);

    // Noise then load, then reload from RUN
    t0 = tx_q.size();
    fr = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h07};
    send_frame(2);
    idle(12);
    chk("t5_resp", 32'(tx_q[t0]), 32'h06);
    chk("t5_ntx", 32'(tx_q.size() - t0), 32'd1);
    send_byte(8'h33, 1);
    send_byte(8'hA5, 0);
    chk("t5_rehold", 32'(bus.o_cpu_hold), 32'd1);
    fr = {8'h01, 8'h33, 8'h44, 8'h77};
    send_frame(1);
    idle(12);

    // Reset mid-frame
    w0 = wa_q.size();
    fr = {8'hA5, 8'h01, 8'h12};
    send_frame(0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_hold", 32'(bus.o_cpu_hold), 32'd1);
    chk("t6_error", 32'(bus.o_error), 32'd0);
    chk("t6_we", 32'(bus.o_we), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("t6_nowrite", 32'(wa_q.size() - w0), 32'd0);
    fr = {8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_frame(1);
    idle(12);
    chk("t6_addr", 32'(wa_q[w0]), 32'd0);
    chk("t6_data", 32'(wd_q[w0]), 32'hBEEF);
    chk("t6_hold2", 32'(bus.o_cpu_hold), 32'd0);

    // Randomized frames, including one full-length load
    for (int it = 0; it < 25; it++) begin
      fr.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        fr.push_back(b);
      end
      n = (it == 10) ? 255 : (($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6));
      fr.push_back(8'hA5);
      fr.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < 2 * n; k++) begin
        b = 8'($urandom);
        x ^= b;
        fr.push_back(b);
      end
      fr.push_back(($urandom_range(0, 3) == 0) ? 8'(x ^ 8'h01) : x);
      if (n > 0 && $urandom_range(0, 5) == 0) begin
        while (fr.size() > 4) void'(fr.pop_back());
        send_frame(3);
        idle(T + 15);
      end else begin
        send_frame(3);
        idle(14);
      end
    end

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

endmodule
